// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the byte-wide RAM read/write engines between
// port A (CPU) and port B (video/DMA), with a per-access watchdog.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_memory,
  input  logic        aresetn,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [20:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [20:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        rd_en,
  output logic [20:0] rd_addr,
  input  logic        rd_ready,
  input  logic [7:0]  rd_data,
  output logic        wr_signal,
  output logic [20:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, RD_START, RD_WAIT, WR_WAIT, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;      // 1 = port B was served last
  logic          grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_sig_q, wr_sig_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;

  logic          expire_c, pick_b_c, win_we_c, finish_c, load_c;
  logic [DW-1:0] rval_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wdog_d    = wdog_q;
    terr_d    = terr_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    rd_en_d   = 1'b0;
    wr_sig_d  = 1'b0;
    finish_c  = 1'b0;
    load_c    = 1'b0;
    rval_c    = '0;
    expire_c  = (wdog_q == CW'(TIMEOUT - 1));
    pick_b_c  = b_req & (~a_req | ~last_q);
    win_we_c  = pick_b_c ? b_we : a_we;

    case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          grant_d = pick_b_c;
          last_d  = pick_b_c;
          addr_d  = pick_b_c ? b_addr : a_addr;
          wdata_d = pick_b_c ? b_wdata : a_wdata;
          wdog_d  = '0;
          if (win_we_c) begin
            state_d  = WR_WAIT;
            wr_sig_d = 1'b1;
          end else begin
            state_d = RD_START;
            rd_en_d = 1'b1;
          end
        end
      end
      RD_START: begin
        wdog_d = wdog_q + CW'(1);
        if (expire_c) begin
          finish_c = 1'b1;
          load_c   = 1'b1;
          rval_c   = '1;
          terr_d   = 1'b1;
        end else begin
          rd_en_d = 1'b1;
          if (!rd_ready) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        wdog_d = wdog_q + CW'(1);
        // A real completion on the expiry cycle still counts as good
        if (rd_ready) begin
          finish_c = 1'b1;
          load_c   = 1'b1;
          rval_c   = rd_data;
        end else if (expire_c) begin
          finish_c = 1'b1;
          load_c   = 1'b1;
          rval_c   = '1;
          terr_d   = 1'b1;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      WR_WAIT: begin
        wdog_d = wdog_q + CW'(1);
        if (wr_done) begin
          finish_c = 1'b1;
        end else if (expire_c) begin
          finish_c = 1'b1;
          terr_d   = 1'b1;
        end else begin
          wr_sig_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish_c) state_d = RELEASE;
    a_ack_d = finish_c & ~grant_q;
    b_ack_d = finish_c & grant_q;
    if (load_c) begin
      if (grant_q) b_rdata_d = rval_c;
      else         a_rdata_d = rval_c;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_memory or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wdog_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_sig_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wdog_q    <= wdog_d;
      rd_en_q   <= rd_en_d;
      wr_sig_q  <= wr_sig_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = addr_q;
  assign wr_signal   = wr_sig_q;
  assign wr_addr     = addr_q;
  assign wr_data     = wdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural read/write engines plus a transaction-level
// model of arbitration order, completion cycle, rdata and the sticky error flag.
module tb_ram_arbiter;

  localparam int unsigned TO = 16;

  logic        clk_memory = 1'b0;
  logic        aresetn = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [20:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, rd_en, wr_signal, grant, busy, timeout_err;
  logic [7:0]  a_rdata, b_rdata, wr_data;
  logic [20:0] rd_addr, wr_addr;
  logic        rd_ready, wr_done;
  logic [7:0]  rd_data;

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk_memory(clk_memory), .aresetn(aresetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_signal(wr_signal), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_memory = ~clk_memory;

  int errors = 0;
  int checks = 0;

  // Engine behaviour knobs for the access in flight
  logic       rd_hang = 1'b0, wr_hang = 1'b0;
  int         rd_lat = 1, wr_lat = 2;
  logic [7:0] rd_val = '0;

  // Reference model state
  logic       last_b = 1'b1;
  logic       te_m = 1'b0;
  logic [7:0] a_rd_m = '0, b_rd_m = '0;

  // Read engine: ready drops rd_lat cycles after seeing en, then holds result until en falls
  int rs, rcnt;
  always @(posedge clk_memory or negedge aresetn) begin
    if (!aresetn) begin
      rd_ready <= 1'b1; rd_data <= '0; rs <= 0; rcnt <= 0;
    end else begin
      case (rs)
        0: if (rd_en && !rd_hang) begin rd_ready <= 1'b0; rcnt <= rd_lat - 1; rs <= 1; end
        1: if (rcnt == 0) begin rd_ready <= 1'b1; rd_data <= rd_val; rs <= 2; end
           else rcnt <= rcnt - 1;
        default: if (!rd_en) rs <= 0;
      endcase
    end
  end

  // Write engine: done pulse lands so that wr_signal is high exactly wr_lat cycles
  int wseen;
  always @(posedge clk_memory or negedge aresetn) begin
    if (!aresetn) begin
      wseen <= 0; wr_done <= 1'b0;
    end else if (wr_signal && !wr_hang) begin
      wseen   <= wseen + 1;
      wr_done <= (wseen + 1 == wr_lat - 1);
    end else begin
      wseen <= 0; wr_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_b = 1'b1; te_m = 1'b0; a_rd_m = '0; b_rd_m = '0;
  endtask

  // One arbitrated access; lat==0 picks a random in-budget latency
  task automatic serve_one(input bit hang, input int lat, input logic [7:0] val, input bit drop);
    bit w, we, hold_ok;
    logic [20:0] ad;
    logic [7:0]  wd;
    int waited, k, exp_k, l;
    w  = b_req && (!a_req || !last_b);
    last_b = w;
    we = w ? b_we : a_we;
    ad = w ? b_addr : a_addr;
    wd = w ? b_wdata : a_wdata;
    l  = lat;
    if (l == 0) l = we ? int'($urandom_range(TO, 2)) : int'($urandom_range(TO - 2, 1));
    rd_hang = hang; wr_hang = hang; rd_lat = l; wr_lat = l; rd_val = val;
    waited = 0;
    do begin @(negedge clk_memory); waited++; end while (!busy && waited < 4);
    check("grant_latency", waited, 1);
    check("grant", grant, w);
    check("path", {rd_en, wr_signal}, we ? 2'b01 : 2'b10);
    check("addr", we ? wr_addr : rd_addr, ad);
    exp_k = hang ? TO + 1 : (we ? l + 1 : l + 3);
    k = 1; hold_ok = 1'b1;
    while (!(a_ack || b_ack) && k < TO + 8) begin
      @(negedge clk_memory); k++;
      if (!(a_ack || b_ack))
        hold_ok &= (grant == w) && (we ? (wr_signal && !rd_en && wr_addr == ad && wr_data == wd)
                                       : (rd_en && !wr_signal && rd_addr == ad));
    end
    te_m |= hang;
    if (!we) begin
      if (w) b_rd_m = hang ? 8'hFF : val;
      else   a_rd_m = hang ? 8'hFF : val;
    end
    check("hold_stable", hold_ok, 1);
    check("ack_cycle", k, exp_k);
    check("ack_port", {a_ack, b_ack}, w ? 2'b01 : 2'b10);
    check("eng_off_at_ack", {rd_en, wr_signal, busy}, 3'b001);
    check("a_rdata", a_rdata, a_rd_m);
    check("b_rdata", b_rdata, b_rd_m);
    check("timeout_err", timeout_err, te_m);
    @(negedge clk_memory);
    check("release", {a_ack, b_ack, rd_en, wr_signal, busy}, 0);
    if (drop) begin
      if (w) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk_memory);
    check("rst_ctrl", {a_ack, b_ack, rd_en, wr_signal, grant, busy, timeout_err}, 0);
    check("rst_rdata", {a_rdata, b_rdata, wr_data}, 0);
    check("rst_addr", {rd_addr, wr_addr}, 0);
    aresetn = 1'b1;
    @(negedge clk_memory);

    // Plain read, ready low 5 cycles
    a_req = 1; a_we = 0; a_addr = 21'h01234;
    serve_one(0, 5, 8'h5A, 1);

    // Write from B, 3-cycle done
    b_req = 1; b_we = 1; b_addr = 21'h1FFFF; b_wdata = 8'hC3;
    serve_one(0, 3, 8'h00, 1);

    // Both reading and held: round-robin alternation
    a_req = 1; a_we = 0; a_addr = 21'h0AAAA;
    b_req = 1; b_we = 0; b_addr = 21'h15555;
    serve_one(0, 2, 8'h11, 0);
    serve_one(0, 3, 8'h22, 0);
    serve_one(0, 4, 8'h33, 0);
    serve_one(0, 1, 8'h44, 0);
    a_req = 0; b_req = 0;

    // Completion on the watchdog-expiry cycle wins
    a_req = 1; a_we = 1; a_addr = 21'h00F00; a_wdata = 8'h3C;
    serve_one(0, TO, 8'h00, 1);
    b_req = 1; b_we = 0; b_addr = 21'h1F0F0;
    serve_one(0, TO - 2, 8'hA5, 1);

    // Engine never starts: watchdog read
    a_req = 1; a_we = 0; a_addr = 21'h00042;
    serve_one(1, 1, 8'h00, 1);

    // Cache hit: ready low only one cycle
    a_req = 1; a_we = 0; a_addr = 21'h10001;
    serve_one(0, 1, 8'h77, 1);

    // Randomised traffic
    for (int it = 0; it < 30; it++) begin
      int m, cnt;
      m = int'($urandom_range(3, 1));
      if (m[0]) begin a_req = 1; a_we = 1'($urandom); a_addr = 21'($urandom); a_wdata = 8'($urandom); end
      if (m[1]) begin b_req = 1; b_we = 1'($urandom); b_addr = 21'($urandom); b_wdata = 8'($urandom); end
      cnt = (m == 3) ? 2 : 1;
      for (int s = 0; s < cnt; s++)
        serve_one(($urandom_range(7, 0) == 0), 0, 8'($urandom), 1);
    end

    // Reset in the middle of a hung write
    a_req = 1; a_we = 1; a_addr = 21'h0ABCD; a_wdata = 8'h11; wr_hang = 1; rd_hang = 0;
    n = 0;
    do begin @(negedge clk_memory); n++; end while (!wr_signal && n < 5);
    check("mid_wr_entered", wr_signal, 1);
    repeat (3) @(negedge clk_memory);
    b_req = 1; b_we = 0; b_addr = 21'h00777;
    #1 aresetn = 1'b0;
    #1;
    check("async_drop", {wr_signal, busy, rd_en, a_ack, b_ack}, 0);
    check("async_terr", timeout_err, 0);
    @(negedge clk_memory);
    aresetn = 1'b1;
    model_reset();
    serve_one(0, 4, 8'h00, 1);
    serve_one(0, 3, 8'h9E, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
